pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the three-stage pipeline (stage_one / stage_two / stage_three).
- Generates operand-forwarding selects, load-use stalls, branch flushes, multi-cycle (mul/div) stall windows and the halt drain sequence.
- Drives the `stall` and `halt_sys` signals consumed by stage_one and stage_two.

Parameters:
- RIDX_W, 4, register index width (16 registers).
- MCYC_LAT, 4, total execute cycles of a mul/div op; stall window = MCYC_LAT-1 cycles; legal range 2..15.
- DRAIN_CYC, 2, bubble cycles between halt decode and halt_sys assertion.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- s1_valid  in  1  stage-1 instruction is valid
- s1_rs1  in  RIDX_W  first source register index
- s1_rs1_used  in  1  instruction reads rs1
- s1_rs2  in  RIDX_W  second source register index
- s1_rs2_used  in  1  instruction reads rs2
- s1_mcyc  in  1  stage-1 instruction is mul/div
- s1_halt  in  1  stage-1 instruction is HALT
- s2_rd  in  RIDX_W  stage-2 destination index
- s2_reg_wr  in  1  stage-2 writes s2_rd
- s2_R0_en  in  1  stage-2 writes R0 (upper product/remainder)
- s2_load  in  1  stage-2 is a memory read
- s3_rd  in  RIDX_W  stage-3 destination index
- s3_reg_wr  in  1  stage-3 writes s3_rd
- s3_R0_en  in  1  stage-3 writes R0
- branch_taken  in  1  branch resolved taken in stage 2
- stall  out  1  hold PC and stage-1 register
- flush  out  1  inject bubble into stage-2 register
- fwd_a  out  2  operand A source, type fwd_sel_e
- fwd_b  out  2  operand B source, type fwd_sel_e
- mcyc_busy  out  1  multi-cycle op in progress
- halt_sys  out  1  system halted; sticky

Behaviour:
- Reset (rst=0, async):
  - State RUN, counter 0, halt_sys 0.
  - With all inputs 0: stall 0, flush 0, fwd_a/fwd_b FWD_RF, mcyc_busy 0.
- Write match for source register rs in stage N:
  - match = (sN_reg_wr && sN_rd==rs) || (sN_R0_en && rs==0).
  - The source's `_used` bit must be 1 and s1_valid must be 1.
- Forwarding (combinational, same cycle):
  - FWD_S2 (aluout) if the stage-2 write matches and s2_load=0.
  - Otherwise FWD_S3 (s3_data) if the stage-3 write matches.
  - Otherwise FWD_RF.
  - Stage 2 has priority over stage 3.
- Load-use (RUN only):
  - A stage-2 match with s2_load=1 gives stall=1 and flush=1 for exactly 1 cycle.
  - Next cycle the load is in stage 3, so that forward is FWD_S3.
  - Fwd value is don't-care during the stall cycle.
- Branch: branch_taken=1 forces flush=1 and stall=0 in the same cycle, in any state except HALTED. It overrides load-use.
- FSM:
  - RUN:
    - s1_valid && s1_halt → HALT_DRAIN, counter=DRAIN_CYC-1.
    - Else s1_valid && s1_mcyc and no load-use → MCYC, counter=MCYC_LAT-2.
    - stall = load-use only.
  - MCYC:
    - stall=1, mcyc_busy=1, flush=0; counter decrements each cycle; at counter==0 → RUN.
    - Stall cycles = MCYC_LAT-1.
    - branch_taken aborts: → RUN, counter=0, flush=1.
  - HALT_DRAIN:
    - stall=1, flush=1, counter decrements; at counter==0 → HALTED.
    - branch_taken cancels the halt (branch is older): → RUN.
  - HALTED:
    - halt_sys=1 (registered, asserted on entry), stall=1, flush=1.
    - All inputs ignored; exit only via reset.
- Simultaneous events:
  - s1_halt and s1_mcyc both set: halt wins.
  - Load-use and s1_mcyc: load-use stall first; MCYC is entered the following cycle when s1 re-presents the instruction.
- Counter width is 4 bits; no wrap occurs for legal parameters.
- Reset mid-MCYC or mid-drain returns immediately to RUN with all outputs at their reset values.

Decomposition:
- types_pkg gains:
  - fwd_sel_e (FWD_RF=2'd0, FWD_S2=2'd1, FWD_S3=2'd2).
  - ctrl_state_e (RUN, MCYC, HALT_DRAIN, HALTED).
- One sub-module, fwd_unit: purely combinational match and priority logic, instantiated once per operand.

Test Plan:
- Reset, then s2_reg_wr=1, s2_rd=5, s1_rs1=5, s1_rs1_used=1 → fwd_a=FWD_S2; also s3_rd=5, s3_reg_wr=1 → still FWD_S2.
- s2_load=1, s2_rd=3, s1_rs2=3, s1_rs2_used=1 → stall=1, flush=1 for 1 cycle; next cycle s3_rd=3 → fwd_b=FWD_S3, stall=0.
- s1_mcyc=1 with MCYC_LAT=4 → stall high for exactly 3 cycles, mcyc_busy high likewise; branch_taken in cycle 2 → flush=1, stall=0, state RUN.
- s2_R0_en=1, s1_rs1=0, s1_rs1_used=1, s2_reg_wr=0 → fwd_a=FWD_S2.
- s1_halt=1 with DRAIN_CYC=2 → stall and flush for 2 cycles, then halt_sys=1, stays 1 for 20 cycles under random inputs.
- Repeat halt with branch_taken during drain → halt_sys stays 0; assert rst=0 mid-MCYC → outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_S2 = 2'd1,
        FWD_S3 = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MCYC       = 2'd1,
        HALT_DRAIN = 2'd2,
        HALTED     = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Per-operand write-match and forwarding priority; purely combinational.
module fwd_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int RIDX_W = 4
) (
    input  logic              s1_valid,
    input  logic [RIDX_W-1:0] rs,
    input  logic              rs_used,
    input  logic [RIDX_W-1:0] s2_rd,
    input  logic              s2_reg_wr,
    input  logic              s2_R0_en,
    input  logic              s2_load,
    input  logic [RIDX_W-1:0] s3_rd,
    input  logic              s3_reg_wr,
    input  logic              s3_R0_en,
    output fwd_sel_e          fwd_sel,
    output logic              load_use
);

    logic active;
    logic rs_zero;
    logic match_s2;
    logic match_s3;

    assign active   = s1_valid && rs_used;
    assign rs_zero  = (rs == '0);
    // R0 also receives the upper product/remainder, so it matches on its own enable
    assign match_s2 = active && ((s2_reg_wr && (s2_rd == rs)) || (s2_R0_en && rs_zero));
    assign match_s3 = active && ((s3_reg_wr && (s3_rd == rs)) || (s3_R0_en && rs_zero));
    assign load_use = match_s2 && s2_load;

    always_comb begin
        fwd_sel = FWD_RF;
        if (match_s2 && !s2_load) begin
            fwd_sel = FWD_S2;
        end else if (match_s3) begin
            fwd_sel = FWD_S3;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: forwarding, load-use stall, branch flush,
// mul/div stall window and halt drain.
//   state      | meaning
//   RUN        | normal issue; stall only on load-use
//   MCYC       | mul/div executing, front end held
//   HALT_DRAIN | halt decoded, bubbling the pipe
//   HALTED     | halt_sys asserted until reset
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int RIDX_W    = 4,
    parameter int MCYC_LAT  = 4,
    parameter int DRAIN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s1_valid,
    input  logic [RIDX_W-1:0] s1_rs1,
    input  logic              s1_rs1_used,
    input  logic [RIDX_W-1:0] s1_rs2,
    input  logic              s1_rs2_used,
    input  logic              s1_mcyc,
    input  logic              s1_halt,
    input  logic [RIDX_W-1:0] s2_rd,
    input  logic              s2_reg_wr,
    input  logic              s2_R0_en,
    input  logic              s2_load,
    input  logic [RIDX_W-1:0] s3_rd,
    input  logic              s3_reg_wr,
    input  logic              s3_R0_en,
    input  logic              branch_taken,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mcyc_busy,
    output logic              halt_sys
);

    ctrl_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    fwd_sel_e         sel_a, sel_b;
    logic             lu_a, lu_b, load_use;

    fwd_unit #(.RIDX_W(RIDX_W)) u_fwd_a (
        .s1_valid (s1_valid),
        .rs       (s1_rs1),
        .rs_used  (s1_rs1_used),
        .s2_rd    (s2_rd),
        .s2_reg_wr(s2_reg_wr),
        .s2_R0_en (s2_R0_en),
        .s2_load  (s2_load),
        .s3_rd    (s3_rd),
        .s3_reg_wr(s3_reg_wr),
        .s3_R0_en (s3_R0_en),
        .fwd_sel  (sel_a),
        .load_use (lu_a)
    );

    fwd_unit #(.RIDX_W(RIDX_W)) u_fwd_b (
        .s1_valid (s1_valid),
        .rs       (s1_rs2),
        .rs_used  (s1_rs2_used),
        .s2_rd    (s2_rd),
        .s2_reg_wr(s2_reg_wr),
        .s2_R0_en (s2_R0_en),
        .s2_load  (s2_load),
        .s3_rd    (s3_rd),
        .s3_reg_wr(s3_reg_wr),
        .s3_R0_en (s3_R0_en),
        .fwd_sel  (sel_b),
        .load_use (lu_b)
    );

    assign fwd_a    = sel_a;
    assign fwd_b    = sel_b;
    assign load_use = lu_a || lu_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            cnt      <= '0;
            halt_sys <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state_nxt == HALTED) begin
                halt_sys <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        flush     = 1'b0;
        mcyc_busy = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    // stage-1 instruction is wrong-path; do not act on it
                    flush = 1'b1;
                end else begin
                    stall = load_use;
                    flush = load_use;
                    if (s1_valid && s1_halt) begin
                        state_nxt = HALT_DRAIN;
                        cnt_nxt   = CNT_W'(DRAIN_CYC - 1);
                    end else if (s1_valid && s1_mcyc && !load_use) begin
                        state_nxt = MCYC;
                        cnt_nxt   = CNT_W'(MCYC_LAT - 2);
                    end
                end
            end
            MCYC: begin
                mcyc_busy = 1'b1;
                if (branch_taken) begin
                    flush     = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    stall = 1'b1;
                    if (cnt == '0) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
            end
            HALT_DRAIN: begin
                flush = 1'b1;
                if (branch_taken) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    stall = 1'b1;
                    if (cnt == '0) begin
                        state_nxt = HALTED;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
            end
            HALTED: begin
                stall = 1'b1;
                flush = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with hand-computed expectations.
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst;
    logic       s1_valid;
    logic [3:0] s1_rs1;
    logic       s1_rs1_used;
    logic [3:0] s1_rs2;
    logic       s1_rs2_used;
    logic       s1_mcyc;
    logic       s1_halt;
    logic [3:0] s2_rd;
    logic       s2_reg_wr;
    logic       s2_R0_en;
    logic       s2_load;
    logic [3:0] s3_rd;
    logic       s3_reg_wr;
    logic       s3_R0_en;
    logic       branch_taken;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mcyc_busy;
    logic       halt_sys;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    localparam logic [1:0] RF = 2'd0;
    localparam logic [1:0] S2 = 2'd1;
    localparam logic [1:0] S3 = 2'd2;

    pipeline_ctrl #(.RIDX_W(4), .MCYC_LAT(4), .DRAIN_CYC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .s1_valid    (s1_valid),
        .s1_rs1      (s1_rs1),
        .s1_rs1_used (s1_rs1_used),
        .s1_rs2      (s1_rs2),
        .s1_rs2_used (s1_rs2_used),
        .s1_mcyc     (s1_mcyc),
        .s1_halt     (s1_halt),
        .s2_rd       (s2_rd),
        .s2_reg_wr   (s2_reg_wr),
        .s2_R0_en    (s2_R0_en),
        .s2_load     (s2_load),
        .s3_rd       (s3_rd),
        .s3_reg_wr   (s3_reg_wr),
        .s3_R0_en    (s3_R0_en),
        .branch_taken(branch_taken),
        .stall       (stall),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .mcyc_busy   (mcyc_busy),
        .halt_sys    (halt_sys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // advance one clock; inputs are then driven 1ns after the edge, checks 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s1_valid = 0; s1_rs1 = 0; s1_rs1_used = 0; s1_rs2 = 0; s1_rs2_used = 0;
        s1_mcyc = 0; s1_halt = 0; s2_rd = 0; s2_reg_wr = 0; s2_R0_en = 0;
        s2_load = 0; s3_rd = 0; s3_reg_wr = 0; s3_R0_en = 0; branch_taken = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_flush"}, flush, 0);
        check({tag, "_busy"}, mcyc_busy, 0);
        check({tag, "_halt"}, halt_sys, 0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #3;
        check_idle("reset");
        check("reset_fwd_a", fwd_a, RF);
        check("reset_fwd_b", fwd_b, RF);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // forwarding priority
        s1_valid = 1; s2_reg_wr = 1; s2_rd = 5; s1_rs1 = 5; s1_rs1_used = 1;
        #1;
        check("fwd_s2", fwd_a, S2);
        check("fwd_s2_b_rf", fwd_b, RF);
        s3_rd = 5; s3_reg_wr = 1;
        #1;
        check("fwd_s2_over_s3", fwd_a, S2);
        s2_reg_wr = 0;
        #1;
        check("fwd_s3", fwd_a, S3);
        s1_rs1_used = 0;
        #1;
        check("fwd_unused", fwd_a, RF);
        clear_inputs();

        // R0 implicit writes
        s1_valid = 1; s2_R0_en = 1; s1_rs1 = 0; s1_rs1_used = 1;
        #1;
        check("r0_s2", fwd_a, S2);
        s1_rs1 = 1;
        #1;
        check("r0_nonzero", fwd_a, RF);
        s2_R0_en = 0; s3_R0_en = 1; s1_rs2 = 0; s1_rs2_used = 1;
        #1;
        check("r0_s3_b", fwd_b, S3);
        s1_valid = 0;
        #1;
        check("r0_invalid", fwd_b, RF);
        clear_inputs();
        tick();

        // load-use stall, then forward from stage 3
        s1_valid = 1; s2_load = 1; s2_reg_wr = 1; s2_rd = 3; s1_rs2 = 3; s1_rs2_used = 1;
        #1;
        check("lu_stall", stall, 1);
        check("lu_flush", flush, 1);
        branch_taken = 1;
        #1;
        check("lu_br_stall", stall, 0);
        check("lu_br_flush", flush, 1);
        branch_taken = 0;
        tick();
        s2_load = 0; s2_reg_wr = 0; s3_rd = 3; s3_reg_wr = 1;
        #1;
        check("lu_next_fwd_b", fwd_b, S3);
        check("lu_next_stall", stall, 0);
        check("lu_next_flush", flush, 0);
        clear_inputs();

        // load-use with mul/div: MCYC deferred
        s1_valid = 1; s1_mcyc = 1; s2_load = 1; s2_reg_wr = 1; s2_rd = 7; s1_rs1 = 7; s1_rs1_used = 1;
        #1;
        check("lumc_stall", stall, 1);
        tick();
        check("lumc_not_busy", mcyc_busy, 0);
        s2_load = 0; s2_reg_wr = 0;
        #1;
        check("lumc_issue_stall", stall, 0);
        tick();
        clear_inputs();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lumc_win%0d_stall", i), stall, 1);
            check($sformatf("lumc_win%0d_busy", i), mcyc_busy, 1);
            tick();
        end
        check_idle("lumc_done");

        // MCYC window of MCYC_LAT-1 = 3 cycles
        s1_valid = 1; s1_mcyc = 1;
        #1;
        check("mc_issue_stall", stall, 0);
        check("mc_issue_busy", mcyc_busy, 0);
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mc_win%0d_stall", i), stall, 1);
            check($sformatf("mc_win%0d_busy", i), mcyc_busy, 1);
            check($sformatf("mc_win%0d_flush", i), flush, 0);
            tick();
        end
        check_idle("mc_done");

        // branch aborts MCYC in cycle 2
        s1_valid = 1; s1_mcyc = 1;
        tick();
        clear_inputs();
        #1;
        check("mcab_c1_stall", stall, 1);
        tick();
        branch_taken = 1;
        #1;
        check("mcab_c2_stall", stall, 0);
        check("mcab_c2_flush", flush, 1);
        tick();
        branch_taken = 0;
        #1;
        check_idle("mcab_run");

        // halt cancelled by a branch during drain
        s1_valid = 1; s1_halt = 1;
        tick();
        clear_inputs();
        #1;
        check("hcan_d1_stall", stall, 1);
        check("hcan_d1_flush", flush, 1);
        branch_taken = 1;
        #1;
        check("hcan_br_stall", stall, 0);
        check("hcan_br_flush", flush, 1);
        tick();
        branch_taken = 0;
        #1;
        check_idle("hcan_run");
        tick(); tick();
        check("hcan_later_halt", halt_sys, 0);

        // asynchronous reset mid-MCYC
        s1_valid = 1; s1_mcyc = 1;
        tick();
        clear_inputs();
        tick();
        check("armc_busy", mcyc_busy, 1);
        rst = 1'b0;
        #1;
        check_idle("armc");
        #1;
        rst = 1'b1;
        tick();
        check_idle("armc_after");

        // halt (with mcyc also set): 2 drain cycles, then sticky halt_sys
        s1_valid = 1; s1_halt = 1; s1_mcyc = 1;
        tick();
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("drain%0d_stall", i), stall, 1);
            check($sformatf("drain%0d_flush", i), flush, 1);
            check($sformatf("drain%0d_busy", i), mcyc_busy, 0);
            check($sformatf("drain%0d_halt", i), halt_sys, 0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            s1_valid = 1'($urandom); s1_rs1 = 4'($urandom); s1_rs1_used = 1'($urandom);
            s1_rs2 = 4'($urandom); s1_rs2_used = 1'($urandom); s1_mcyc = 1'($urandom);
            s1_halt = 1'($urandom); s2_rd = 4'($urandom); s2_reg_wr = 1'($urandom);
            s2_R0_en = 1'($urandom); s2_load = 1'($urandom); s3_rd = 4'($urandom);
            s3_reg_wr = 1'($urandom); s3_R0_en = 1'($urandom); branch_taken = 1'($urandom);
            #1;
            check($sformatf("halted%0d_halt", i), halt_sys, 1);
            check($sformatf("halted%0d_stall", i), stall, 1);
            check($sformatf("halted%0d_flush", i), flush, 1);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
